draw_sequencer: RTL and testbench

//  Top-level draw-phase controller, successor to the single-stage draw FSM. Per command it

---
 rtl/draw_pkg.sv | 26 ++
 rtl/draw_watchdog.sv | 34 +++
 rtl/draw_sequencer.sv | 134 +++++++++++++
 tb/tb_draw_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared state encoding and width helpers for the draw-phase sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package draw_pkg;

  localparam int STATE_W = 3;

  // Codes 3 and 4 are unused and steer back to PRE_DRAW.
  typedef enum logic [STATE_W-1:0] {
    PRE_DRAW = 3'd0,
    READ     = 3'd1,
    STAGE    = 3'd2,
    DONE     = 3'd5,
    IDLE     = 3'd6,
    ERROR    = 3'd7
  } state_t;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/draw_watchdog.sv
// Stall watchdog: counts consecutive enabled cycles, flags expiry on the TIMEOUT_CYCLES-th one.
// Latency: expired is combinational from the registered count; count updates 1 clk later.
// Backpressure: none; clear or a dropped count_en restarts the count from zero.
module draw_watchdog
  import draw_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int              CW    = clog2_min1(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count dwell cycles; saturate at the limit so expiry stays asserted until the FSM reacts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !count_en) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = count_en && (cnt == LIMIT);

endmodule

// File: rtl/draw_sequencer.sv
// Draw-phase controller: per command, read then NUM_STAGES ordered go/done stages; counts commands.
// Latency: 1 clk from input to state change; Moore outputs decoded from registered state/idx.
// Backpressure: each go is held until its done arrives; optional watchdog (DRAW_SEQ_TIMEOUT_EN) aborts stalls.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int CNT_W          = 8,
  parameter int MAX_CMDS       = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  program_reset,
  input  logic                  start_process,
  output logic                  end_process,
  input  logic                  data_reset_done,
  output logic                  go_reset_data,
  output logic                  go_read_processor,
  input  logic                  finished_all,
  input  logic                  command_read,
  output logic [NUM_STAGES-1:0] go_stage,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [CNT_W-1:0]      cmd_count,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [STATE_W-1:0]    current_state
);

  localparam int                IDX_W     = clog2_min1(NUM_STAGES);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_W-1:0]  CMD_LIMIT = CNT_W'(MAX_CMDS);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sel_done;
  logic             expired;

  // Pick out the done bit of the active stage; all other bits are ignored.
  always_comb begin
    sel_done = 1'b0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx == IDX_W'(k)) sel_done = stage_done[k];
    end
  end

`ifdef DRAW_SEQ_TIMEOUT_EN
  logic wd_clear;

  // Any progress (state or stage index moving) restarts the stall count.
  assign wd_clear = (state_nxt != state) || (idx_nxt != idx);

  draw_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (program_reset),
    .clear    (wd_clear),
    .count_en (busy),
    .expired  (expired)
  );

  assign timeout_err = (state == ERROR);
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next state, stage index and command count; handshakes take priority over watchdog expiry.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cmd_count;
    case (state)
      PRE_DRAW: if (data_reset_done && start_process) state_nxt = READ;
      READ: begin
        if (finished_all) begin
          state_nxt = DONE;
        end else if (command_read) begin
          state_nxt = STAGE;
          idx_nxt   = '0;
        end else if (expired) begin
          state_nxt = ERROR;
        end
      end
      STAGE: begin
        if (sel_done) begin
          if (idx != LAST_IDX) begin
            idx_nxt = idx + 1'b1;
          end else begin
            cnt_nxt = cmd_count + 1'b1;
            if (MAX_CMDS != 0 && cnt_nxt == CMD_LIMIT) state_nxt = DONE;
            else                                      state_nxt = READ;
          end
        end else if (expired) begin
          state_nxt = ERROR;
        end
      end
      DONE, ERROR: if (!start_process) state_nxt = IDLE;
      IDLE:        if (start_process)  state_nxt = PRE_DRAW;
      default:     state_nxt = PRE_DRAW;
    endcase
    // The count reads zero for the whole time we sit in PRE_DRAW.
    if (state_nxt == PRE_DRAW) cnt_nxt = '0;
  end

  // State, stage index and command counter registers.
  always_ff @(posedge clk or posedge program_reset) begin
    if (program_reset) begin
      state     <= PRE_DRAW;
      idx       <= '0;
      cmd_count <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cmd_count <= cnt_nxt;
    end
  end

  // Moore output decode; go_stage is one-hot on the active stage.
  always_comb begin
    go_stage = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      go_stage[k] = (state == STAGE) && (idx == IDX_W'(k));
    end
  end

  assign go_reset_data     = (state == PRE_DRAW);
  assign go_read_processor = (state == READ);
  assign end_process       = (state == DONE);
  assign busy              = (state == READ) || (state == STAGE);
  assign current_state     = state;

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: two instances (unlimited 3-bit counter, MAX_CMDS=2) share stimulus.
// Directed scenarios first, then randomized inputs with occasional async resets.
// Every cycle all outputs are compared against a behavioural model of the command flow.
module tb_draw_sequencer;

  localparam int NS  = 3;
  localparam int TMO = 16;
`ifdef DRAW_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, sp, drd, fa, cr;
  logic [2:0] sd;

  logic       end_p [2];
  logic       grd   [2];
  logic       grp   [2];
  logic       bsy   [2];
  logic       terr  [2];
  logic [2:0] gst   [2];
  logic [2:0] cst   [2];
  logic [2:0] cc0;
  logic [7:0] cc1;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: phase uses the published state codes, stage position, completed count, dwell cycles.
  int ph    [2];
  int ix    [2];
  int cnt   [2];
  int dwell [2];
  int cmax  [2] = '{0, 2};
  int cmask [2] = '{7, 255};

  always #5 clk = ~clk;

  draw_sequencer #(.NUM_STAGES(NS), .CNT_W(3), .MAX_CMDS(0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .clk(clk), .program_reset(rst), .start_process(sp), .end_process(end_p[0]),
    .data_reset_done(drd), .go_reset_data(grd[0]), .go_read_processor(grp[0]),
    .finished_all(fa), .command_read(cr), .go_stage(gst[0]), .stage_done(sd),
    .cmd_count(cc0), .busy(bsy[0]), .timeout_err(terr[0]), .current_state(cst[0])
  );

  draw_sequencer #(.NUM_STAGES(NS), .CNT_W(8), .MAX_CMDS(2), .TIMEOUT_CYCLES(TMO)) dut1 (
    .clk(clk), .program_reset(rst), .start_process(sp), .end_process(end_p[1]),
    .data_reset_done(drd), .go_reset_data(grd[1]), .go_read_processor(grp[1]),
    .finished_all(fa), .command_read(cr), .go_stage(gst[1]), .stage_done(sd),
    .cmd_count(cc1), .busy(bsy[1]), .timeout_err(terr[1]), .current_state(cst[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ph[d] = 0; ix[d] = 0; cnt[d] = 0; dwell[d] = 0;
    end
  endtask

  // One clock edge of the command flow for instance d, using the current inputs.
  task automatic mstep(input int d);
    int nph;
    int nix;
    int ncnt;
    bit moved;
    nph  = ph[d];
    nix  = ix[d];
    ncnt = cnt[d];
    case (ph[d])
      0: if (drd && sp) nph = 1;
      1: begin
        if (fa) nph = 5;
        else if (cr) begin nph = 2; nix = 0; end
      end
      2: begin
        if (sd[ix[d]]) begin
          if (ix[d] < NS - 1) nix = ix[d] + 1;
          else begin
            ncnt = (cnt[d] + 1) & cmask[d];
            nph  = (cmax[d] != 0 && ncnt == cmax[d]) ? 5 : 1;
          end
        end
      end
      5, 7: if (!sp) nph = 6;
      6: if (sp) nph = 0;
      default: nph = 0;
    endcase
    moved = (nph != ph[d]) || (nix != ix[d]);
    if (TO_EN && (ph[d] == 1 || ph[d] == 2) && !moved && dwell[d] >= TMO) nph = 7;
    if (nph != ph[d] || nix != ix[d]) dwell[d] = 1;
    else if (dwell[d] < 100000) dwell[d] = dwell[d] + 1;
    if (nph == 0) ncnt = 0;
    ph[d]  = nph;
    ix[d]  = nix;
    cnt[d] = ncnt;
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d current_state", d), 32'(cst[d]), 32'(ph[d]));
      chk($sformatf("d%0d go_reset_data", d), 32'(grd[d]), 32'(ph[d] == 0));
      chk($sformatf("d%0d go_read_processor", d), 32'(grp[d]), 32'(ph[d] == 1));
      chk($sformatf("d%0d end_process", d), 32'(end_p[d]), 32'(ph[d] == 5));
      chk($sformatf("d%0d busy", d), 32'(bsy[d]), 32'(ph[d] == 1 || ph[d] == 2));
      chk($sformatf("d%0d timeout_err", d), 32'(terr[d]), 32'(ph[d] == 7));
      chk($sformatf("d%0d go_stage", d), 32'(gst[d]), (ph[d] == 2) ? (32'd1 << ix[d]) : 32'd0);
      chk($sformatf("d%0d cmd_count", d), (d == 0) ? 32'(cc0) : 32'(cc1), 32'(cnt[d]));
    end
  endtask

  // Async reset pulse placed between clock edges; outputs must settle before the next edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    #1;
    rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
    compare_all();
  endtask

  task automatic cyc(input logic a, input logic b, input logic c, input logic e, input logic [2:0] s);
    sp = a; drd = b; fa = c; cr = e; sd = s;
    step();
  endtask

  initial begin
    rst = 1'b0; sp = 1'b0; drd = 1'b0; fa = 1'b0; cr = 1'b0; sd = 3'b000;
    do_reset();

    // Start: PRE_DRAW -> READ in one clock.
    cyc(1, 1, 0, 0, 3'b000);
    // One command through three stages, each go held until its done.
    cyc(1, 1, 0, 1, 3'b000);
    cyc(1, 1, 0, 0, 3'b000);
    cyc(1, 1, 0, 0, 3'b000);
    cyc(1, 1, 0, 0, 3'b001);
    cyc(1, 1, 0, 0, 3'b000);
    cyc(1, 1, 0, 0, 3'b010);
    cyc(1, 1, 0, 0, 3'b000);
    cyc(1, 1, 0, 0, 3'b100);
    // Second command: done bits off the active stage are ignored; MAX_CMDS=2 instance stops.
    cyc(1, 1, 0, 1, 3'b000);
    cyc(1, 1, 0, 0, 3'b001);
    cyc(1, 1, 0, 0, 3'b101);
    cyc(1, 1, 0, 0, 3'b010);
    cyc(1, 1, 0, 0, 3'b100);
    // finished_all beats command_read; then drop start to reach IDLE.
    cyc(1, 1, 1, 1, 3'b000);
    cyc(0, 1, 0, 0, 3'b000);
    cyc(1, 1, 0, 0, 3'b000);
    cyc(1, 1, 0, 0, 3'b000);
    // Stall a stage long past the watchdog limit, then reset out of whatever state results.
    cyc(1, 1, 0, 1, 3'b000);
    for (int i = 0; i < TMO + 4; i++) cyc(1, 1, 0, 0, 3'b000);
    do_reset();

    // Randomized phase with quiet windows to provoke stalls and rare async resets.
    for (int i = 0; i < 3000; i++) begin
      bit quiet;
      quiet = ((i % 200) >= 170);
      sp  = ($urandom_range(0, 9) != 0);
      drd = ($urandom_range(0, 9) < 7);
      fa  = quiet ? 1'b0 : ($urandom_range(0, 19) == 0);
      cr  = quiet ? 1'b0 : ($urandom_range(0, 1) == 1);
      sd  = quiet ? 3'b000 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
